// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: byte-lane stores, extended loads,
// fixed access latency with pipeline stall, and misalignment/illegal-funct3 reporting.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        req_ready,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state, next_state;
  logic [CW-1:0]   count, next_count;
  logic            write_q;
  logic [AW+1:0]   addr_q;
  logic [31:0]     wdata_q;
  logic [2:0]      funct3_q;

  logic [3:0][7:0] mem [DEPTH_WORDS];

  logic            accept, enter_resp;
  logic            cur_write;
  logic [AW+1:0]   cur_addr;
  logic [31:0]     cur_wdata;
  logic [2:0]      cur_funct3;
  logic [AW-1:0]   cur_idx;
  logic            legal, misaligned, acc_err;
  logic [31:0]     word, load_data, store_data;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [3:0]      byte_en;
  logic            unused_addr_hi;

  assign unused_addr_hi = ^req_addr[31:AW+2];

  assign accept     = (state == IDLE) && req_valid;
  assign enter_resp = (next_state == RESP);
  assign req_ready  = (state == IDLE);
  assign stall      = accept || (state == WAIT);
  assign rsp_valid  = (state == RESP);

  // With LATENCY=1 the commit edge is the acceptance edge, so decode from the live request.
  assign cur_write  = (state == IDLE) ? req_write  : write_q;
  assign cur_addr   = (state == IDLE) ? req_addr[AW+1:0] : addr_q;
  assign cur_wdata  = (state == IDLE) ? req_wdata  : wdata_q;
  assign cur_funct3 = (state == IDLE) ? req_funct3 : funct3_q;
  assign cur_idx    = cur_addr[AW+1:2];

  always_comb begin
    next_state = state;
    next_count = count;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (LATENCY == 1) begin
            next_state = RESP;
          end else begin
            next_state = WAIT;
            next_count = CW'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (count <= CW'(1)) begin
          next_state = RESP;
          next_count = '0;
        end else begin
          next_count = count - CW'(1);
        end
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    if (cur_write)
      legal = (cur_funct3 == 3'b000) || (cur_funct3 == 3'b001) || (cur_funct3 == 3'b010);
    else
      legal = (cur_funct3 == 3'b000) || (cur_funct3 == 3'b001) || (cur_funct3 == 3'b010) ||
              (cur_funct3 == 3'b100) || (cur_funct3 == 3'b101);
    misaligned = ((cur_funct3[1:0] == 2'b01) && cur_addr[0]) ||
                 ((cur_funct3[1:0] == 2'b10) && (cur_addr[1:0] != 2'b00));
    acc_err    = !legal || misaligned;
  end

  always_comb begin
    word = mem[cur_idx];
    case (cur_addr[1:0])
      2'b00:   byte_sel = word[7:0];
      2'b01:   byte_sel = word[15:8];
      2'b10:   byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = cur_addr[1] ? word[31:16] : word[15:0];
    case (cur_funct3)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b010:  load_data = word;
      3'b100:  load_data = {24'h0, byte_sel};
      3'b101:  load_data = {16'h0, half_sel};
      default: load_data = 32'h0;
    endcase
  end

  // Store data is replicated across lanes so the byte enables alone pick the target bytes.
  always_comb begin
    case (cur_funct3[1:0])
      2'b00: begin
        store_data = {4{cur_wdata[7:0]}};
        byte_en    = 4'b0001 << cur_addr[1:0];
      end
      2'b01: begin
        store_data = {2{cur_wdata[15:0]}};
        byte_en    = cur_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        store_data = cur_wdata;
        byte_en    = 4'b1111;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && enter_resp && cur_write && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[cur_idx][i] <= store_data[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      funct3_q  <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= next_state;
      count <= next_count;
      if (accept) begin
        write_q  <= req_write;
        addr_q   <= req_addr[AW+1:0];
        wdata_q  <= req_wdata;
        funct3_q <= req_funct3;
      end
      if (enter_resp) begin
        rsp_err   <= acc_err;
        rsp_rdata <= (acc_err || cur_write) ? 32'h0 : load_data;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (DEPTH_WORDS=1024, LATENCY=2).
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        req_ready;
  logic        stall;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int tests_run    = 0;
  int tests_failed = 0;

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_funct3(req_funct3),
    .req_ready(req_ready), .stall(stall), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // Issue one access from an IDLE negedge and return its response; lat=0 means none arrived.
  task automatic do_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [2:0] f3, output logic [31:0] rd,
                           output logic er, output int lat);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_funct3 = f3;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h0; req_funct3 = 3'b111;
    lat = 0; rd = 32'h0; er = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      if (rsp_valid) begin
        lat = n; rd = rsp_rdata; er = rsp_err;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; req_funct3 = 3'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_ready got %b want 1", req_ready); end
    tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_stall got %b want 0", stall); end
    tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_valid got %b want 0", rsp_valid); end
    tests_run++; if (rsp_rdata !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_rdata got %h want 0", rsp_rdata); end
    tests_run++; if (rsp_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_err got %b want 0", rsp_err); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_sw_lw();
    logic [31:0] rd; logic er; int lat;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10; req_wdata = 32'hDEADBEEF; req_funct3 = 3'b010;
    #1;
    tests_run++; if (stall !== 1'b1) begin tests_failed++; $display("[TB] FAIL sw_stall_t got %b want 1", stall); end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    #1;
    tests_run++; if (stall !== 1'b1) begin tests_failed++; $display("[TB] FAIL sw_stall_t1 got %b want 1", stall); end
    tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL sw_valid_t1 got %b want 0", rsp_valid); end
    tests_run++; if (req_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL sw_ready_t1 got %b want 0", req_ready); end
    @(negedge clk);
    tests_run++; if (rsp_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL sw_valid_t2 got %b want 1", rsp_valid); end
    tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("[TB] FAIL sw_stall_t2 got %b want 0", stall); end
    tests_run++; if (rsp_rdata !== 32'h0) begin tests_failed++; $display("[TB] FAIL sw_rdata got %h want 0", rsp_rdata); end
    tests_run++; if (rsp_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL sw_err got %b want 0", rsp_err); end
    @(negedge clk);
    tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL sw_valid_t3 got %b want 0", rsp_valid); end
    tests_run++; if (rsp_rdata !== 32'h0) begin tests_failed++; $display("[TB] FAIL sw_rdata_hold got %h want 0", rsp_rdata); end
    do_access(1'b0, 32'h10, 32'h0, 3'b010, rd, er, lat);
    tests_run++; if (lat !== 2) begin tests_failed++; $display("[TB] FAIL lw_latency got %0d want 2", lat); end
    tests_run++; if (rd !== 32'hDEADBEEF) begin tests_failed++; $display("[TB] FAIL lw_rdata got %h want deadbeef", rd); end
    tests_run++; if (rsp_rdata !== 32'hDEADBEEF) begin tests_failed++; $display("[TB] FAIL lw_rdata_hold got %h want deadbeef", rsp_rdata); end
  endtask

  task automatic test_subword_loads();
    logic [31:0] rd; logic er; int lat;
    do_access(1'b0, 32'h13, 32'h0, 3'b000, rd, er, lat);
    tests_run++; if (rd !== 32'hFFFFFFDE || lat !== 2) begin tests_failed++; $display("[TB] FAIL lb got %h lat %0d want ffffffde lat 2", rd, lat); end
    do_access(1'b0, 32'h13, 32'h0, 3'b100, rd, er, lat);
    tests_run++; if (rd !== 32'h000000DE) begin tests_failed++; $display("[TB] FAIL lbu got %h want 000000de", rd); end
    do_access(1'b0, 32'h10, 32'h0, 3'b001, rd, er, lat);
    tests_run++; if (rd !== 32'hFFFFBEEF) begin tests_failed++; $display("[TB] FAIL lh got %h want ffffbeef", rd); end
    do_access(1'b0, 32'h12, 32'h0, 3'b101, rd, er, lat);
    tests_run++; if (rd !== 32'h0000DEAD) begin tests_failed++; $display("[TB] FAIL lhu got %h want 0000dead", rd); end
  endtask

  task automatic test_subword_stores();
    logic [31:0] rd; logic er; int lat;
    do_access(1'b1, 32'h11, 32'h000000AA, 3'b000, rd, er, lat);
    tests_run++; if (rd !== 32'h0 || er !== 1'b0 || lat !== 2) begin tests_failed++; $display("[TB] FAIL sb_rsp got %h err %b lat %0d want 0 0 2", rd, er, lat); end
    do_access(1'b0, 32'h10, 32'h0, 3'b010, rd, er, lat);
    tests_run++; if (rd !== 32'hDEADAAEF) begin tests_failed++; $display("[TB] FAIL sb_readback got %h want deadaaef", rd); end
    do_access(1'b1, 32'h12, 32'h00001234, 3'b001, rd, er, lat);
    do_access(1'b0, 32'h10, 32'h0, 3'b010, rd, er, lat);
    tests_run++; if (rd !== 32'h1234AAEF) begin tests_failed++; $display("[TB] FAIL sh_readback got %h want 1234aaef", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat;
    do_access(1'b0, 32'h12, 32'h0, 3'b010, rd, er, lat);
    tests_run++; if (er !== 1'b1 || rd !== 32'h0 || lat !== 2) begin tests_failed++; $display("[TB] FAIL lw_misaligned got err %b rdata %h lat %0d want 1 0 2", er, rd, lat); end
    do_access(1'b1, 32'h11, 32'h0000FFFF, 3'b001, rd, er, lat);
    tests_run++; if (er !== 1'b1) begin tests_failed++; $display("[TB] FAIL sh_misaligned got err %b want 1", er); end
    do_access(1'b1, 32'h10, 32'h0, 3'b100, rd, er, lat);
    tests_run++; if (er !== 1'b1) begin tests_failed++; $display("[TB] FAIL store_illegal got err %b want 1", er); end
    do_access(1'b0, 32'h10, 32'h0, 3'b010, rd, er, lat);
    tests_run++; if (rd !== 32'h1234AAEF || er !== 1'b0) begin tests_failed++; $display("[TB] FAIL err_no_write got %h err %b want 1234aaef 0", rd, er); end
    do_access(1'b0, 32'h10, 32'h0, 3'b011, rd, er, lat);
    tests_run++; if (er !== 1'b1 || rd !== 32'h0) begin tests_failed++; $display("[TB] FAIL load_illegal got err %b rdata %h want 1 0", er, rd); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd; logic er; int lat;
    do_access(1'b1, 32'h20, 32'hCAFEF00D, 3'b010, rd, er, lat);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h00000055; req_funct3 = 3'b010;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL abort_wait_valid got %b want 0", rsp_valid); end
    @(negedge clk);
    rst = 1'b0;
    tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL abort_valid got %b want 0", rsp_valid); end
    tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL abort_ready got %b want 1", req_ready); end
    @(negedge clk);
    tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL abort_late_valid got %b want 0", rsp_valid); end
    do_access(1'b0, 32'h20, 32'h0, 3'b010, rd, er, lat);
    tests_run++; if (rd !== 32'hCAFEF00D) begin tests_failed++; $display("[TB] FAIL abort_readback got %h want cafef00d", rd); end
  endtask

  task automatic test_wrap();
    logic [31:0] rd; logic er; int lat;
    do_access(1'b1, 32'h1000, 32'h13579BDF, 3'b010, rd, er, lat);
    do_access(1'b0, 32'h0, 32'h0, 3'b010, rd, er, lat);
    tests_run++; if (rd !== 32'h13579BDF) begin tests_failed++; $display("[TB] FAIL wrap got %h want 13579bdf", rd); end
  endtask

  task automatic test_back_to_back();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_funct3 = 3'b010;
    @(posedge clk);
    @(negedge clk);
    tests_run++; if (stall !== 1'b1 || rsp_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_wait got stall %b valid %b want 1 0", stall, rsp_valid); end
    @(negedge clk);
    req_addr = 32'h13; req_funct3 = 3'b100;
    #1;
    tests_run++; if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || stall !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_resp got valid %b ready %b stall %b want 1 0 0", rsp_valid, req_ready, stall); end
    tests_run++; if (rsp_rdata !== 32'h1234AAEF) begin tests_failed++; $display("[TB] FAIL b2b_first got %h want 1234aaef", rsp_rdata); end
    @(negedge clk);
    tests_run++; if (req_ready !== 1'b1 || stall !== 1'b1 || rsp_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_idle got ready %b stall %b valid %b want 1 1 0", req_ready, stall, rsp_valid); end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_addr = 32'h10; req_funct3 = 3'b010;
    @(negedge clk);
    tests_run++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h00000012) begin tests_failed++; $display("[TB] FAIL b2b_second got valid %b rdata %h want 1 00000012", rsp_valid, rsp_rdata); end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    test_reset();
    test_sw_lw();
    test_subword_loads();
    test_subword_stores();
    test_errors();
    test_reset_abort();
    test_wrap();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
